// File: rtl/shift_reg_unit.sv
// ============================================================================
//  Module   : shift_reg_unit
//  Purpose  : WIDTH-bit universal register. It supports hold, load, clear,
//             and shift/rotate in both directions, with complementary outputs.
//             A burst mode steps a latched shift/rotate op a programmed
//             number of times and uses a busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_reg_unit #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qbar_o,
    output logic             sout_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               sout_q, sout_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         mlat_q, mlat_d;

    // Op applied this cycle: the latched burst op in BURST, the live mode otherwise
    logic [2:0]         op_mode;
    logic [WIDTH-1:0]   step_q;
    logic               step_sout;
    logic               start_is_shift;

    assign op_mode        = (state_q == ST_BURST) ? mlat_q : mode_i;
    assign start_is_shift = (mode_i[2:1] == 2'b01) || (mode_i[2:1] == 2'b10);

    // Single-step datapath: the result of applying op_mode once to the current contents
    always_comb begin
        step_q    = q_q;
        step_sout = sout_q;
        case (op_mode)
            MODE_LOAD: step_q = d_i;
            MODE_CLR:  step_q = '0;
            MODE_SHL: begin
                step_q    = {q_q[WIDTH-2:0], sin_i};
                step_sout = q_q[WIDTH-1];
            end
            MODE_SHR: begin
                step_q    = {sin_i, q_q[WIDTH-1:1]};
                step_sout = q_q[0];
            end
            MODE_ROL: begin
                step_q    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                step_sout = q_q[WIDTH-1];
            end
            MODE_ROR: begin
                step_q    = {q_q[0], q_q[WIDTH-1:1]};
                step_sout = q_q[0];
            end
            default: ;  // hold encodings leave contents and sout untouched
        endcase
    end

    // Next-state logic: single ops in IDLE, burst launch and per-step countdown
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mlat_d  = mlat_q;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    if (start_i && start_is_shift) begin
                        if (len_i == '0) begin
                            done_d = 1'b1;  // zero-length burst completes with no step
                        end else begin
                            state_d = ST_BURST;
                            cnt_d   = len_i;
                            mlat_d  = mode_i;
                        end
                    end else begin
                        q_d    = step_q;
                        sout_d = step_sout;
                    end
                end
            end
            ST_BURST: begin
                if (en_i) begin
                    q_d    = step_q;
                    sout_d = step_sout;
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with asynchronous abort to the idle/cleared condition
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mlat_q  <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mlat_q  <= mlat_d;
        end
    end

    assign q_o    = q_q;
    assign qbar_o = ~q_q;
    assign sout_o = sout_q;
    assign busy_o = (state_q == ST_BURST);
    assign done_o = done_q;

endmodule

`default_nettype wire
